pa_spsram_req_ctrl: RTL and testbench



---
 rtl/pa_spsram_req_ctrl_pkg.sv | 36 +++
 rtl/pa_spsram_req_ctrl_if.sv | 39 +++
 rtl/pa_spsram_rsp_fifo.sv | 61 ++++++
 rtl/pa_spsram_req_ctrl.sv | 137 +++++++++++++
 tb/tb_pa_spsram_req_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pa_spsram_req_ctrl_pkg.sv
// Shared definitions for the SRAM request controller.
//   - access size encodings (SIZE_B / SIZE_H / SIZE_W; 2'b11 is reserved)
//   - response buffer depth and count width
//   - response entry type {err, rdata}
//   - lane_wmask(): active-high bit mask of the byte lanes a store touches
package pa_spsram_req_ctrl_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int RSP_DEPTH = 2;
  localparam int RSP_CNT_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_ent_t;

  // Bit mask (1 = written) for a store of the given size at byte offset off.
  function automatic logic [31:0] lane_wmask(input logic [1:0] size,
                                             input logic [1:0] off);
    logic [3:0]  lanes;
    logic [31:0] mask;
    case (size)
      SIZE_B:  lanes = 4'b0001 << off;
      SIZE_H:  lanes = off[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{lanes[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/pa_spsram_req_ctrl_if.sv
// Request/response bus between the LSU (master) and the SRAM request
// controller (slave).
//   req_vld/req_rdy  request handshake; req_wr, req_addr (byte), req_size,
//                    req_wdata (right-justified)
//   req_sign         only with PA_SPSRAM_REQ_CTRL_SEXT_EN: sign-extend load
//   rsp_vld/rsp_rdy  response handshake; rsp_rdata, rsp_err
interface pa_spsram_req_ctrl_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [1:0]            req_size;
  logic [31:0]           req_wdata;
`ifdef PA_SPSRAM_REQ_CTRL_SEXT_EN
  logic                  req_sign;
`endif
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

`ifdef PA_SPSRAM_REQ_CTRL_SEXT_EN
  modport master (output req_vld, req_wr, req_addr, req_size, req_wdata,
                         req_sign, rsp_rdy,
                  input  req_rdy, rsp_vld, rsp_rdata, rsp_err);
  modport slave  (input  req_vld, req_wr, req_addr, req_size, req_wdata,
                         req_sign, rsp_rdy,
                  output req_rdy, rsp_vld, rsp_rdata, rsp_err);
`else
  modport master (output req_vld, req_wr, req_addr, req_size, req_wdata,
                         rsp_rdy,
                  input  req_rdy, rsp_vld, rsp_rdata, rsp_err);
  modport slave  (input  req_vld, req_wr, req_addr, req_size, req_wdata,
                         rsp_rdy,
                  output req_rdy, rsp_vld, rsp_rdata, rsp_err);
`endif
endinterface

// File: rtl/pa_spsram_rsp_fifo.sv
// Two-entry response FIFO, head kept in a register (entry 0).
//   clk, rst        clock, asynchronous active-high reset (clears count)
//   push_a/din_a    older push (load data returning from the SRAM)
//   push_b/din_b    younger push (store/error response accepted this cycle)
//   pop             remove head
//   head, count     head entry and number of valid entries
// Two pushes in one cycle are needed because a load in its data cycle and a
// newly accepted store/error both complete at the same edge; the caller's
// admission rule guarantees room for both.
module pa_spsram_rsp_fifo
  import pa_spsram_req_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_a,
  input  rsp_ent_t             din_a,
  input  logic                 push_b,
  input  rsp_ent_t             din_b,
  input  logic                 pop,
  output rsp_ent_t             head,
  output logic [RSP_CNT_W-1:0] count
);

  rsp_ent_t             ent0, ent1, nxt0, nxt1;
  logic [RSP_CNT_W-1:0] cnt, nxt_cnt;

  // Pop shifts entry 1 to the head, then pushes append in age order.
  always_comb begin
    nxt0    = ent0;
    nxt1    = ent1;
    nxt_cnt = cnt;
    if (pop) begin
      nxt0    = ent1;
      nxt_cnt = nxt_cnt - RSP_CNT_W'(1);
    end
    if (push_a) begin
      if (nxt_cnt == '0) nxt0 = din_a;
      else               nxt1 = din_a;
      nxt_cnt = nxt_cnt + RSP_CNT_W'(1);
    end
    if (push_b) begin
      if (nxt_cnt == '0) nxt0 = din_b;
      else               nxt1 = din_b;
      nxt_cnt = nxt_cnt + RSP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= nxt_cnt;
  end

  always_ff @(posedge clk) begin
    ent0 <= nxt0;
    ent1 <= nxt1;
  end

  assign head  = ent0;
  assign count = cnt;

endmodule

// File: rtl/pa_spsram_req_ctrl.sv
// Initiator-side controller for the 8192x32 single-port SRAM macro.
// Optional feature macro: PA_SPSRAM_REQ_CTRL_SEXT_EN (adds bus.req_sign,
// sign-extends byte/half loads when set).
//   forever_cpuclk   sole clock, rising edge
//   cpurst           asynchronous active-high reset
//   bus (slave)      request/response bus, see pa_spsram_req_ctrl_if
//   sram_a/cen/gwen/wen/d   SRAM pins (active-low enables), driven
//                           combinationally in the accept cycle
//   sram_q           SRAM read data, valid the cycle after a read
// Stores and errors respond one cycle after accept, loads two cycles after.
module pa_spsram_req_ctrl
  import pa_spsram_req_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  pa_spsram_req_ctrl_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  function automatic logic [31:0] lane_extract(input logic [31:0] q,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sext);
    logic [31:0] sh;
    logic [31:0] r;
    sh = q >> {off, 3'b000};
    case (size)
      SIZE_B:  r = {{24{sext & sh[7]}},  sh[7:0]};
      SIZE_H:  r = {{16{sext & sh[15]}}, sh[15:0]};
      default: r = q;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] wd,
                                            input logic [1:0]  size);
    logic [31:0] r;
    case (size)
      SIZE_B:  r = {4{wd[7:0]}};
      SIZE_H:  r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  logic                 acc, req_err, ld_acc;
  logic                 inflight_p0;
  logic [1:0]           off_p0, size_p0;
  logic                 sext_p0;
  logic [RSP_CNT_W-1:0] cnt;
  rsp_ent_t             ld_ent, now_ent, head;
  logic                 push_now, pop;

  // ---- accept stage: admission, error decode, SRAM drive ----
  assign req_err = (bus.req_size == 2'b11) ||
                   (bus.req_size == SIZE_H && bus.req_addr[0]) ||
                   (bus.req_size == SIZE_W && bus.req_addr[1:0] != 2'b00);

  // In-flight loads reserve a buffer slot so their data always has room.
  assign bus.req_rdy = ~cpurst &
                       (({1'b0, cnt} + {{RSP_CNT_W{1'b0}}, inflight_p0}) <
                        (RSP_CNT_W + 1)'(RSP_DEPTH));
  assign acc    = bus.req_vld & bus.req_rdy;
  assign ld_acc = acc & ~bus.req_wr & ~req_err;

  always_comb begin
    sram_a    = '0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_d    = '0;
    if (acc && !req_err) begin
      sram_cen = 1'b0;
      sram_a   = bus.req_addr[ADDR_WIDTH+1:2];
      if (bus.req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~lane_wmask(bus.req_size, bus.req_addr[1:0]);
        sram_d    = replicate(bus.req_wdata, bus.req_size);
      end
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) inflight_p0 <= 1'b0;
    else        inflight_p0 <= ld_acc;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (ld_acc) begin
      off_p0  <= bus.req_addr[1:0];
      size_p0 <= bus.req_size;
`ifdef PA_SPSRAM_REQ_CTRL_SEXT_EN
      sext_p0 <= bus.req_sign;
`endif
    end
  end

`ifndef PA_SPSRAM_REQ_CTRL_SEXT_EN
  assign sext_p0 = 1'b0;
`endif

  // ---- data stage: lane extraction and response buffering ----
  assign ld_ent.err   = 1'b0;
  assign ld_ent.rdata = lane_extract(sram_q, off_p0, size_p0, sext_p0);

  assign now_ent.err   = req_err;
  assign now_ent.rdata = '0;
  assign push_now      = acc & (bus.req_wr | req_err);

  assign pop = bus.rsp_vld & bus.rsp_rdy;

  pa_spsram_rsp_fifo u_rsp_fifo (
    .clk    (forever_cpuclk),
    .rst    (cpurst),
    .push_a (inflight_p0),
    .din_a  (ld_ent),
    .push_b (push_now),
    .din_b  (now_ent),
    .pop    (pop),
    .head   (head),
    .count  (cnt)
  );

  // Head storage is not reset; gating keeps the outputs zero while empty.
  assign bus.rsp_vld   = (cnt != '0);
  assign bus.rsp_rdata = bus.rsp_vld ? head.rdata : 32'h0;
  assign bus.rsp_err   = bus.rsp_vld & head.err;

endmodule

// File: tb/tb_pa_spsram_req_ctrl.sv
module tb_pa_spsram_req_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pa_spsram_req_ctrl_if bus ();

  logic [12:0] sram_a;
  logic        sram_cen, sram_gwen;
  logic [31:0] sram_wen, sram_d, sram_q;

  pa_spsram_req_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (bus),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // SRAM macro behaviour: bitwise write, registered read.
  logic [31:0] smem [0:8191];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) smem[sram_a] <= (smem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= smem[sram_a];
    end
  end

  // Reference model: byte-addressed memory and ordered expected responses.
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          avail;
  } exp_t;

  logic [7:0] rmem [0:32767];
  exp_t       expq [$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

`ifdef PA_SPSRAM_REQ_CTRL_SEXT_EN
  localparam bit SEXT = 1'b1;
`else
  localparam bit SEXT = 1'b0;
`endif

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic do_cycle(input logic v, input logic wr, input logic [14:0] addr,
                          input logic [1:0] size, input logic [31:0] wd,
                          input logic sg, input logic rr, output logic accepted);
    logic        exp_rdy, err, exp_vld;
    int          nb;
    logic [31:0] wen_exp, d_exp, val;
    exp_t        e;
    bus.req_vld   = v;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wd;
`ifdef PA_SPSRAM_REQ_CTRL_SEXT_EN
    bus.req_sign  = sg;
`endif
    bus.rsp_rdy   = rr;
    @(negedge clk);
    exp_rdy = (expq.size() < 2);
    chk1("req_rdy", bus.req_rdy, exp_rdy);
    accepted = v && exp_rdy;
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    chk1("sram_cen", sram_cen, !(accepted && !err));
    if (accepted && !err) begin
      chk32("sram_a", 32'(sram_a), 32'(addr[14:2]));
      chk1("sram_gwen", sram_gwen, !wr);
      if (wr) begin
        wen_exp = 32'hFFFF_FFFF;
        for (int i = 0; i < nb; i++) wen_exp[8*(int'(addr[1:0]) + i) +: 8] = 8'h00;
        d_exp = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
        chk32("sram_wen", sram_wen, wen_exp);
        chk32("sram_d", sram_d, d_exp);
      end else begin
        chk32("sram_wen_rd", sram_wen, 32'hFFFF_FFFF);
      end
    end
    exp_vld = (expq.size() > 0) && (expq[0].avail <= cyc);
    chk1("rsp_vld", bus.rsp_vld, exp_vld);
    if (exp_vld && rr) begin
      e = expq.pop_front();
      chk1("rsp_err", bus.rsp_err, e.err);
      chk32("rsp_rdata", bus.rsp_rdata, e.rdata);
    end
    if (accepted) begin
      e.err   = err;
      e.rdata = 32'h0;
      e.avail = cyc + ((wr || err) ? 1 : 2);
      if (!err) begin
        if (wr) begin
          for (int i = 0; i < nb; i++) rmem[int'(addr) + i] = wd[8*i +: 8];
        end else begin
          val = 32'h0;
          for (int i = 0; i < nb; i++) val[8*i +: 8] = rmem[int'(addr) + i];
          if (SEXT && sg && nb == 1 && val[7])  val[31:8]  = 24'hFF_FFFF;
          if (SEXT && sg && nb == 2 && val[15]) val[31:16] = 16'hFFFF;
          e.rdata = val;
        end
      end
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic wr, input logic [14:0] addr, input logic [1:0] size,
                      input logic [31:0] wd, input logic sg);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) do_cycle(1'b1, wr, addr, size, wd, sg, 1'b1, acc);
    chk1("send_accepted", acc, 1'b1);
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 15'h0, 2'b00, 32'h0, 1'b0, rr, acc);
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && expq.size() != 0; k++) idle(1, 1'b1);
    chk32("drained", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    logic acc;
    for (int i = 0; i < 8192; i++) smem[i] = 32'h0;
    for (int i = 0; i < 32768; i++) rmem[i] = 8'h0;
    sram_q        = 32'h0;
    bus.req_vld   = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 15'h0;
    bus.req_size  = 2'b00;
    bus.req_wdata = 32'h0;
`ifdef PA_SPSRAM_REQ_CTRL_SEXT_EN
    bus.req_sign  = 1'b0;
`endif
    bus.rsp_rdy   = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    bus.req_vld = 1'b1;
    #1;
    chk1("rst_rsp_vld", bus.rsp_vld, 1'b0);
    chk32("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk1("rst_rsp_err", bus.rsp_err, 1'b0);
    chk1("rst_req_rdy", bus.req_rdy, 1'b0);
    chk1("rst_cen", sram_cen, 1'b1);
    chk1("rst_gwen", sram_gwen, 1'b1);
    chk32("rst_wen", sram_wen, 32'hFFFF_FFFF);
    chk32("rst_a", 32'(sram_a), 32'h0);
    chk32("rst_d", sram_d, 32'h0);
    bus.req_vld = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Word store then word load
    send(1'b1, 15'h0010, 2'b10, 32'hDEAD_BEEF, 1'b0);
    send(1'b0, 15'h0010, 2'b10, 32'h0, 1'b0);
    drain();

    // Byte store into top lane, word readback
    send(1'b1, 15'h0013, 2'b00, 32'h0000_005A, 1'b0);
    send(1'b0, 15'h0010, 2'b10, 32'h0, 1'b0);
    drain();

    // Misaligned half and reserved size
    send(1'b0, 15'h0011, 2'b01, 32'h0, 1'b0);
    send(1'b0, 15'h0010, 2'b11, 32'h0, 1'b0);
    drain();

    // Backpressure: two loads fill the buffer, third waits for a pop
    do_cycle(1'b1, 1'b0, 15'h0010, 2'b10, 32'h0, 1'b0, 1'b0, acc);
    do_cycle(1'b1, 1'b0, 15'h0012, 2'b01, 32'h0, 1'b0, 1'b0, acc);
    for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b0, 15'h0013, 2'b00, 32'h0, 1'b0, 1'b0, acc);
    chk1("third_held", acc, 1'b0);
    send(1'b0, 15'h0013, 2'b00, 32'h0, 1'b0);
    drain();

    // Sign handling on a byte load of 8'h80
    send(1'b1, 15'h0021, 2'b00, 32'h0000_0080, 1'b0);
    send(1'b0, 15'h0021, 2'b00, 32'h0, 1'b1);
    send(1'b0, 15'h0021, 2'b00, 32'h0, 1'b0);
    drain();

    // Reset while a load is in flight and a store response is buffered
    do_cycle(1'b1, 1'b1, 15'h0040, 2'b10, 32'h1234_5678, 1'b0, 1'b0, acc);
    do_cycle(1'b1, 1'b0, 15'h0040, 2'b10, 32'h0, 1'b0, 1'b0, acc);
    bus.req_vld  = 1'b1;
    bus.req_wr   = 1'b0;
    bus.req_size = 2'b10;
    rst = 1'b1;
    #1;
    chk1("midrst_rsp_vld", bus.rsp_vld, 1'b0);
    chk1("midrst_cen", sram_cen, 1'b1);
    chk1("midrst_req_rdy", bus.req_rdy, 1'b0);
    expq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [14:0] ra;
      logic [1:0]  rs;
      ra = 15'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ra = 15'($urandom);
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (rs == 2'd1) ra[0] = 1'b0;
        if (rs == 2'd2) ra[1:0] = 2'b00;
      end
      do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, rs,
               $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
